// File: rtl/rename_pkg.sv
// Shared widths, sizes and the renamed-instruction record for the rename stage.
package rename_pkg;
  localparam int unsigned ARCH_REGS = 32;
  localparam int unsigned PHYS_REGS = 64;
  localparam int unsigned AREG_W    = 5;
  localparam int unsigned PREG_W    = 6;
  localparam int unsigned FL_DEPTH  = PHYS_REGS - ARCH_REGS;
  localparam int unsigned FL_PTR_W  = 5;
  localparam int unsigned FL_CNT_W  = 7;

  typedef struct packed {
    logic [PREG_W-1:0] psrc1;
    logic [PREG_W-1:0] psrc2;
    logic [PREG_W-1:0] pdest;
    logic [PREG_W-1:0] old_pdest;
    logic              alloc;
  } renamed_t;
endpackage

// File: rtl/free_list.sv
// Circular FIFO of free physical registers, preloaded with the registers
// not covered by the identity mapping at reset.
module free_list
  import rename_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic                push,
  input  logic [PREG_W-1:0]   push_preg,
  input  logic                pop,
  output logic [PREG_W-1:0]   pop_preg,
  output logic                empty,
  output logic                full,
  output logic [FL_CNT_W-1:0] count
);
  logic [PREG_W-1:0]   mem [FL_DEPTH];
  logic [FL_PTR_W-1:0] head;
  logic [FL_PTR_W-1:0] tail;
  logic                do_push;
  logic                do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FL_CNT_W'(FL_DEPTH));
  // A push into a full list is a protocol error; the entry is dropped.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_preg = mem[head];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < FL_DEPTH; i++) begin
        mem[FL_PTR_W'(i)] <= PREG_W'(ARCH_REGS + i);
      end
      head  <= '0;
      tail  <= '0;
      count <= FL_CNT_W'(FL_DEPTH);
    end else begin
      if (do_push) begin
        mem[tail] <= push_preg;
        tail      <= tail + FL_PTR_W'(1);
      end
      if (do_pop) begin
        head <= head + FL_PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + FL_CNT_W'(1);
        2'b01:   count <= count - FL_CNT_W'(1);
        default: ;
      endcase
    end
  end

  no_push_when_full: assert property (@(posedge clk) disable iff (!rstn) !(push && full));
endmodule

// File: rtl/rename_stage.sv
// Register rename: RAT lookup, free-list allocation and a single output
// register towards dispatch, with physical registers reclaimed at commit.
module rename_stage
  import rename_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = 64
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AREG_W-1:0]    in_src1,
  input  logic [AREG_W-1:0]    in_src2,
  input  logic [AREG_W-1:0]    in_dest,
  input  logic                 in_regWrite,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PREG_W-1:0]    out_psrc1,
  output logic [PREG_W-1:0]    out_psrc2,
  output logic [PREG_W-1:0]    out_pdest,
  output logic [PREG_W-1:0]    out_old_pdest,
  output logic                 out_alloc,
  output logic [PAYLOAD_W-1:0] out_payload,
  input  logic                 retire_valid,
  input  logic [PREG_W-1:0]    retire_preg,
  output logic [FL_CNT_W-1:0]  fl_count
);
  logic [PREG_W-1:0]    rat [ARCH_REGS];
  renamed_t             rn;
  renamed_t             out_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic                 need_alloc;
  logic                 accept;
  logic                 fl_pop;
  logic                 fl_empty;
  logic                 fl_full;
  logic [PREG_W-1:0]    fl_head;

  assign need_alloc = in_regWrite && (in_dest != '0);
  // A freed register only becomes visible through fl_empty on the next cycle.
  assign in_ready   = (!out_valid || out_ready) && (!need_alloc || !fl_empty);
  assign accept     = in_valid && in_ready;
  assign fl_pop     = accept && need_alloc;

  always_comb begin
    rn       = '0;
    rn.psrc1 = (in_src1 == '0) ? '0 : rat[in_src1];
    rn.psrc2 = (in_src2 == '0) ? '0 : rat[in_src2];
    if (need_alloc) begin
      rn.pdest     = fl_head;
      rn.old_pdest = rat[in_dest];
      rn.alloc     = 1'b1;
    end
  end

  free_list u_free_list (
    .clk       (clk),
    .rstn      (rstn),
    .push      (retire_valid && (retire_preg != '0)),
    .push_preg (retire_preg),
    .pop       (fl_pop),
    .pop_preg  (fl_head),
    .empty     (fl_empty),
    .full      (fl_full),
    .count     (fl_count)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) begin
        rat[AREG_W'(i)] <= PREG_W'(i);
      end
      out_valid <= 1'b0;
      out_q     <= '0;
      payload_q <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_q     <= rn;
        payload_q <= in_payload;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (fl_pop) begin
        rat[in_dest] <= fl_head;
      end
    end
  end

  assign out_psrc1     = out_q.psrc1;
  assign out_psrc2     = out_q.psrc2;
  assign out_pdest     = out_q.pdest;
  assign out_old_pdest = out_q.old_pdest;
  assign out_alloc     = out_q.alloc;
  assign out_payload   = payload_q;
endmodule
